// File: rtl/dcf77_pkg.sv
// Shared DCF77 definitions: tick thresholds, frame bit positions and the
// layout of the 44-bit BCD time-and-date word consumed by the time-and-date clock.
package dcf77_pkg;

  // Tick counter sizing; the counter saturates at TICK_MAX.
  localparam int              TICK_W     = 8;
  localparam logic [TICK_W-1:0] TICK_MAX = '1;

  // Pulse/gap thresholds in 10 ms ticks.
  localparam logic [TICK_W-1:0] PULSE_MIN  = 8'd5;
  localparam logic [TICK_W-1:0] PULSE_ONE  = 8'd15;
  localparam logic [TICK_W-1:0] PULSE_MAX  = 8'd25;
  localparam logic [TICK_W-1:0] GAP_MARKER = 8'd150;
  localparam logic [TICK_W-1:0] GAP_LOST   = 8'd250;

  // Frame geometry.
  localparam int         FRAME_BITS   = 59;
  localparam logic [5:0] LAST_BIT_CNT = 6'd59;

  // Bit positions inside the received frame (LSB-first BCD).
  localparam int START_POS    = 20;
  localparam int MIN_U_POS    = 21;
  localparam int MIN_T_POS    = 25;
  localparam int MIN_PAR_POS  = 28;
  localparam int HOUR_U_POS   = 29;
  localparam int HOUR_T_POS   = 33;
  localparam int HOUR_PAR_POS = 35;
  localparam int DAY_U_POS    = 36;
  localparam int DAY_T_POS    = 40;
  localparam int WDAY_POS     = 42;
  localparam int MON_U_POS    = 45;
  localparam int MON_T_POS    = 49;
  localparam int YEAR_U_POS   = 50;
  localparam int YEAR_T_POS   = 54;
  localparam int DATE_PAR_POS = 58;

  // Offsets inside the time-and-date word.
  localparam int TD_W        = 44;
  localparam int OUT_SEC_U   = 0;
  localparam int OUT_SEC_T   = 4;
  localparam int OUT_MIN_U   = 7;
  localparam int OUT_MIN_T   = 11;
  localparam int OUT_HOUR_U  = 14;
  localparam int OUT_HOUR_T  = 18;
  localparam int OUT_DAY_T   = 20;
  localparam int OUT_DAY_U   = 22;
  localparam int OUT_MON_T   = 26;
  localparam int OUT_MON_U   = 27;
  localparam int OUT_YEAR_T  = 31;
  localparam int OUT_YEAR_U  = 35;
  localparam int OUT_WDAY    = 39;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    GAP       = 2'd1,
    PULSE     = 2'd2
  } dcfState_t;

  typedef enum logic [1:0] {
    PC_GLITCH   = 2'd0,
    PC_ZERO     = 2'd1,
    PC_ONE      = 2'd2,
    PC_TOO_LONG = 2'd3
  } pulseClass_t;

  function automatic logic bcdOk(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

  // Maps a captured frame onto the time-and-date word; seconds are always 00
  // because the load happens on the rising edge that starts second zero.
  function automatic logic [TD_W-1:0] frameToTd(input logic [FRAME_BITS-1:0] f);
    logic [TD_W-1:0] td;
    td = '0;
    td[OUT_SEC_U  +: 4] = 4'd0;
    td[OUT_SEC_T  +: 3] = 3'd0;
    td[OUT_MIN_U  +: 4] = f[MIN_U_POS  +: 4];
    td[OUT_MIN_T  +: 3] = f[MIN_T_POS  +: 3];
    td[OUT_HOUR_U +: 4] = f[HOUR_U_POS +: 4];
    td[OUT_HOUR_T +: 2] = f[HOUR_T_POS +: 2];
    td[OUT_DAY_U  +: 4] = f[DAY_U_POS  +: 4];
    td[OUT_DAY_T  +: 2] = f[DAY_T_POS  +: 2];
    td[OUT_WDAY   +: 3] = f[WDAY_POS   +: 3];
    td[OUT_MON_U  +: 4] = f[MON_U_POS  +: 4];
    td[OUT_MON_T]       = f[MON_T_POS];
    td[OUT_YEAR_U +: 4] = f[YEAR_U_POS +: 4];
    td[OUT_YEAR_T +: 4] = f[YEAR_T_POS +: 4];
    return td;
  endfunction

endpackage

// File: rtl/dcf77_pulse_timer.sv
// Measures the interval since the last signal edge in 10 ms ticks and
// classifies it as a pulse length or a gap length.
module dcf77_pulse_timer
  import dcf77_pkg::*;
(
  input  logic        clk,
  input  logic        nReset,
  input  logic        clkEn100Hz,
  input  logic        edgeSeen,
  output pulseClass_t pulseClass,
  output logic        markerArmed,
  output logic        signalLost,
  output logic        pulseTooLong
);

  logic [TICK_W-1:0] tickCnt;

  // An edge starts a new interval; a tick in the same clk already belongs to it.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tickCnt <= '0;
    end else if (edgeSeen) begin
      tickCnt <= {{(TICK_W-1){1'b0}}, clkEn100Hz};
    end else if (clkEn100Hz && (tickCnt != TICK_MAX)) begin
      tickCnt <= tickCnt + 8'd1;
    end
  end

  always_comb begin
    pulseClass = PC_TOO_LONG;
    if (tickCnt < PULSE_MIN) begin
      pulseClass = PC_GLITCH;
    end else if (tickCnt < PULSE_ONE) begin
      pulseClass = PC_ZERO;
    end else if (tickCnt <= PULSE_MAX) begin
      pulseClass = PC_ONE;
    end
  end

  assign markerArmed  = (tickCnt >= GAP_MARKER);
  assign signalLost   = (tickCnt >= GAP_LOST);
  assign pulseTooLong = (tickCnt > PULSE_MAX);

endmodule

// File: rtl/dcf77_decoder.sv
// DCF77 frame decoder: synchronizes the receiver output, captures the 59 bits
// of a minute, checks the frame and loads the time-and-date clock on the marker.
module dcf77_decoder
  import dcf77_pkg::*;
(
  input  logic            clk,
  input  logic            nReset,
  input  logic            clkEn100Hz,
  input  logic            dcfSignal_in,
  output logic [TD_W-1:0] timeAndDate_Out,
  output logic            setTimeAndDate_out,
  output logic            synced_out,
  output logic            dcfError_out,
  output dcfState_t       stateDbg
);

  logic                  sync1;
  logic                  sync2;
  logic                  sigPrev;
  logic                  rise;
  logic                  fall;
  logic                  edgeSeen;
  dcfState_t             state;
  logic [5:0]            bitCnt;
  logic [FRAME_BITS-1:0] frameBits;
  logic                  frameValid;
  pulseClass_t           pulseClass;
  logic                  markerArmed;
  logic                  signalLost;
  logic                  pulseTooLong;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sigPrev <= 1'b0;
    end else begin
      sync1   <= dcfSignal_in;
      sync2   <= sync1;
      sigPrev <= sync2;
    end
  end

  assign rise     = sync2 & ~sigPrev;
  assign fall     = ~sync2 & sigPrev;
  assign edgeSeen = rise | fall;

  dcf77_pulse_timer u_pulseTimer (
    .clk          (clk),
    .nReset       (nReset),
    .clkEn100Hz   (clkEn100Hz),
    .edgeSeen     (edgeSeen),
    .pulseClass   (pulseClass),
    .markerArmed  (markerArmed),
    .signalLost   (signalLost),
    .pulseTooLong (pulseTooLong)
  );

  // Frame acceptance: complete minute, start-of-time bit set, three even
  // parity groups, and every four-bit BCD digit in range.
  assign frameValid = (bitCnt == LAST_BIT_CNT)
                   && frameBits[START_POS]
                   && !(^frameBits[MIN_PAR_POS:MIN_U_POS])
                   && !(^frameBits[HOUR_PAR_POS:HOUR_U_POS])
                   && !(^frameBits[DATE_PAR_POS:DAY_U_POS])
                   && bcdOk(frameBits[MIN_U_POS  +: 4])
                   && bcdOk(frameBits[HOUR_U_POS +: 4])
                   && bcdOk(frameBits[DAY_U_POS  +: 4])
                   && bcdOk(frameBits[MON_U_POS  +: 4])
                   && bcdOk(frameBits[YEAR_U_POS +: 4])
                   && bcdOk(frameBits[YEAR_T_POS +: 4]);

  // setTimeAndDate_out is a one-clk strobe; timeAndDate_Out is stable from the
  // strobe cycle until the next accepted frame, so the clock may sample either.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state              <= WAIT_SYNC;
      bitCnt             <= '0;
      frameBits          <= '0;
      timeAndDate_Out    <= '0;
      setTimeAndDate_out <= 1'b0;
      synced_out         <= 1'b0;
      dcfError_out       <= 1'b0;
    end else begin
      setTimeAndDate_out <= 1'b0;
      case (state)
        WAIT_SYNC: begin
          if (rise && markerArmed) begin
            state      <= PULSE;
            bitCnt     <= '0;
            synced_out <= 1'b1;
          end
        end

        GAP: begin
          if (rise) begin
            state <= PULSE;
            if (markerArmed) begin
              bitCnt <= '0;
              if (frameValid) begin
                timeAndDate_Out    <= frameToTd(frameBits);
                setTimeAndDate_out <= 1'b1;
                dcfError_out       <= 1'b0;
                synced_out         <= 1'b1;
              end else begin
                dcfError_out <= 1'b1;
              end
            end
          end else if (signalLost) begin
            state        <= WAIT_SYNC;
            dcfError_out <= 1'b1;
            synced_out   <= 1'b0;
          end
        end

        PULSE: begin
          if (fall) begin
            case (pulseClass)
              PC_GLITCH: begin
                state <= GAP;
              end
              PC_ZERO, PC_ONE: begin
                if (bitCnt == LAST_BIT_CNT) begin
                  state        <= WAIT_SYNC;
                  dcfError_out <= 1'b1;
                  synced_out   <= 1'b0;
                end else begin
                  frameBits[bitCnt] <= (pulseClass == PC_ONE);
                  bitCnt            <= bitCnt + 6'd1;
                  state             <= GAP;
                end
              end
              default: begin
                state        <= WAIT_SYNC;
                dcfError_out <= 1'b1;
                synced_out   <= 1'b0;
              end
            endcase
          end else if (pulseTooLong) begin
            state        <= WAIT_SYNC;
            dcfError_out <= 1'b1;
            synced_out   <= 1'b0;
          end
        end

        default: begin
          state <= WAIT_SYNC;
        end
      endcase
    end
  end

  assign stateDbg = state;

endmodule

// File: doc/dcf77_decoder.md
DCF77_DECODER -- requirements
Module: dcf77_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; no other clock or reset SHALL exist.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 nReset  input  1  asynchronous active-low reset.
REQ-004 clkEn100Hz  input  1  one-clk-wide enable every 10 ms; all timing is counted in these ticks.
REQ-005 dcfSignal_in  input  1  asynchronous DCF77 receiver output; 1 = carrier-reduction pulse active.
REQ-006 timeAndDate_Out  output  44  decoded BCD time/date word, directly loadable into the time-and-date clock.
REQ-007 setTimeAndDate_out  output  1  one-clk load strobe to the clock's set input.
REQ-008 synced_out  output  1  high while a minute marker has been seen and no error has occurred since.
REQ-009 dcfError_out  output  1  sticky error flag, cleared by the next valid frame.

Function
REQ-010 timeAndDate_Out layout SHALL be: [3:0] sec units, [6:4] sec tens, [10:7] min units, [13:11] min tens, [17:14] hour units, [19:18] hour tens, [21:20] day tens, [25:22] day units, [26] month tens, [30:27] month units, [34:31] year tens, [38:35] year units, [41:39] weekday, [43:42] zero.
REQ-011 dcfSignal_in SHALL pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized signal.
REQ-012 The FSM states SHALL be WAIT_SYNC, GAP and PULSE; reset enters WAIT_SYNC.
REQ-013 Pulse length SHALL be counted in ticks: 5..14 = bit 0, 15..25 = bit 1, <5 = glitch (ignored, no bit stored), >25 = error.
REQ-014 Gap length SHALL be counted in ticks while the signal is low: >=150 = minute marker armed, >=250 = signal lost (error).
REQ-015 WAIT_SYNC SHALL wait for an armed minute marker; the next rising edge then moves to PULSE with bitCnt = 0.
REQ-016 In PULSE, a falling edge SHALL store the classified bit at index bitCnt, increment bitCnt and move to GAP.
REQ-017 A rising edge in GAP with a gap below 150 ticks SHALL move to PULSE with no evaluation.
REQ-018 A rising edge in GAP with the marker armed SHALL evaluate the frame; the frame is valid iff bitCnt == 59, bit20 == 1, even parity holds over 21..28, over 29..35 and over 36..58, and all BCD digits are <= 9.
REQ-019 A valid frame SHALL, one clk after the synchronized rising edge, load timeAndDate_Out (seconds = 00, minute bits 21..27, hour bits 29..34, day bits 36..41, weekday bits 42..44, month bits 45..49, year bits 50..57), pulse setTimeAndDate_out for exactly one clk, clear dcfError_out and set synced_out.
REQ-020 An invalid frame SHALL leave timeAndDate_Out unchanged, set dcfError_out, keep synced_out high, restart with bitCnt = 0 and remain in the capture path.
REQ-021 A pulse >25 ticks, a gap >=250 ticks, or a falling edge with bitCnt already at 59 SHALL set dcfError_out, clear synced_out and enter WAIT_SYNC.
REQ-022 Tick counters SHALL saturate and never wrap; edges SHALL be processed in the clk cycle they are detected, independent of clkEn100Hz.
REQ-023 An edge and a tick in the same clk SHALL be handled as the edge, with the tick counted into the new interval (counter = 1).

Reset
REQ-024 On nReset low: timeAndDate_Out = 0, setTimeAndDate_out = 0, synced_out = 0, dcfError_out = 0, bitCnt = 0, tick counters = 0, synchronizer = 0, state = WAIT_SYNC.
REQ-025 Reset mid-frame SHALL discard all captured bits; no strobe SHALL occur until a full new minute has been received.

Structure
REQ-026 Tick thresholds (5, 15, 25, 150, 250), bit-field positions and the output-layout offsets SHALL be defined in the shared package dcf77_pkg, which the time-and-date clock also uses.
REQ-027 Pulse/gap measurement and classification SHALL be the sub-module dcf77_pulse_timer; frame storage, parity check and the FSM SHALL stay in dcf77_decoder.

Verification
REQ-028 Apply reset, then the valid frame for 23:59, 31.12.99, weekday 5, followed by a marker -> one strobe with timeAndDate_Out = {2'b0, 3'd5, 4'h9, 4'h9, 4'h2, 1'b1, 4'h1, 2'h3, 2'h2, 4'h3, 3'h5, 4'h9, 3'h0, 4'h0}, dcfError_out = 0.
REQ-029 Same frame with bit 28 flipped -> no strobe, output unchanged, dcfError_out = 1, synced_out = 1; the next good frame -> strobe and dcfError_out = 0.
REQ-030 Pulses of 4, 5, 14, 15, 25 and 26 ticks -> ignored, 0, 0, 1, 1 and error/WAIT_SYNC respectively.
REQ-031 Gaps of 149, 150 and 250 ticks -> no marker, marker, and signal lost (synced_out = 0, dcfError_out = 1).
REQ-032 Frame of only 58 bits before the marker -> invalid-frame handling; nReset asserted at bit 30 -> all outputs 0 and no strobe at the next marker.
